// File: rtl/sram_stream_reader.sv
// rtl/sram_stream_reader.sv - burst reader turning a latency-1 SRAM read port into a ready/valid stream
// Reads are throttled so FIFO occupancy plus the in-flight read never exceeds the 2-entry FIFO.
module sram_stream_reader #(
   parameter int WWORD = 32,
   parameter int WADDR = 5,
   parameter int DEPTH = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WADDR-1:0] base,
   input  logic [WADDR:0]   len,
   output logic             busy,
   output logic             done,
   output logic [WADDR-1:0] aa,
   output logic             cena,
   input  logic [WWORD-1:0] qa,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [WWORD-1:0] o_data,
   output logic             o_last
);
   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           state_q, state_d;
   logic [WADDR-1:0] addr_q, addr_d;
   logic [WADDR:0]   issue_rem_q, issue_rem_d;
   logic [WADDR:0]   len_q, len_d;
   logic [WADDR:0]   beat_cnt_q, beat_cnt_d;
   logic             done_q, done_d;
   logic             inflight_q;
   logic [WWORD:0]   fifo_q [2];
   logic             rd_ptr_q, wr_ptr_q;
   logic [1:0]       cnt_q;

   logic             issue, push, pop, push_last;
   logic [2:0]       occ;

   assign push      = inflight_q;
   assign pop       = o_valid & o_ready;
   assign push_last = (beat_cnt_q == len_q - (WADDR+1)'(1));
   // Occupancy seen by the issue decision, crediting a beat leaving this cycle.
   assign occ       = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

   assign busy    = (state_q == S_RUN);
   assign done    = done_q;
   assign cena    = ~issue;
   assign aa      = addr_q;
   assign o_valid = (cnt_q != 2'd0);
   assign o_data  = fifo_q[rd_ptr_q][WWORD-1:0];
   assign o_last  = fifo_q[rd_ptr_q][WWORD];

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      issue_rem_d = issue_rem_q;
      len_d       = len_q;
      beat_cnt_d  = beat_cnt_q;
      done_d      = 1'b0;
      issue       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (len != '0) begin
                  state_d     = S_RUN;
                  addr_d      = base;
                  issue_rem_d = len;
                  len_d       = len;
                  beat_cnt_d  = '0;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            issue = (issue_rem_q != '0) && (occ < 3'd2);
            if (issue) begin
               addr_d      = (addr_q == WADDR'(DEPTH-1)) ? '0 : addr_q + WADDR'(1);
               issue_rem_d = issue_rem_q - (WADDR+1)'(1);
            end
            if (push) begin
               beat_cnt_d = beat_cnt_q + (WADDR+1)'(1);
            end
            if (pop && o_last) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         issue_rem_q <= '0;
         len_q       <= '0;
         beat_cnt_q  <= '0;
         done_q      <= 1'b0;
         inflight_q  <= 1'b0;
         fifo_q[0]   <= '0;
         fifo_q[1]   <= '0;
         rd_ptr_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
         cnt_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         issue_rem_q <= issue_rem_d;
         len_q       <= len_d;
         beat_cnt_q  <= beat_cnt_d;
         done_q      <= done_d;
         inflight_q  <= issue;
         if (push) begin
            fifo_q[wr_ptr_q] <= {push_last, qa};
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end
endmodule

// File: tb/tb_sram_stream_reader.sv
// tb/tb_sram_stream_reader.sv - randomized scoreboard bench for sram_stream_reader
module tb_sram_stream_reader;
   localparam int WWORD = 32;
   localparam int WADDR = 5;
   localparam int DEPTH = 24;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [WADDR-1:0] base = '0;
   logic [WADDR:0]   len = '0;
   logic             busy, done, cena, o_valid, o_last;
   logic [WADDR-1:0] aa;
   logic [WWORD-1:0] qa, o_data;
   logic             o_ready = 1'b1;

   always #5 clk = ~clk;

   sram_stream_reader #(.WWORD(WWORD), .WADDR(WADDR), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
      .busy(busy), .done(done), .aa(aa), .cena(cena), .qa(qa),
      .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last)
   );

   // SRAM read port model: data appears the cycle after cena=0
   logic [WWORD-1:0] mem [DEPTH];
   always @(posedge clk) if (!cena) qa <= mem[aa];

   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard state: expected beats {last,data}, issued addresses, event counters
   logic [WWORD:0] exp_q[$];
   int             addr_got[$];
   int             issue_cnt = 0, pop_cnt = 0, done_cnt = 0, outstanding = 0;
   logic           prev_stall = 1'b0;
   logic [WWORD:0] prev_beat = '0;

   always @(negedge clk) begin
      if (rst) begin
         outstanding = 0;
         prev_stall  = 1'b0;
      end else begin
         if (!cena) begin
            issue_cnt++;
            addr_got.push_back(int'(aa));
            check_eq("addr_range", 64'(aa < DEPTH), 64'd1);
         end
         if (prev_stall) check_eq("stall_hold", {o_valid, o_last, o_data}, {1'b1, prev_beat});
         if (o_valid && o_ready) begin
            pop_cnt++;
            check_eq("beat_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) check_eq("beat", {o_last, o_data}, exp_q.pop_front());
         end
         outstanding = outstanding + int'(!cena) - int'(o_valid && o_ready);
         check_eq("outstanding", 64'(outstanding <= 2), 64'd1);
         prev_stall = o_valid && !o_ready;
         prev_beat  = {o_last, o_data};
         if (done) done_cnt++;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ready(input int mode, input int n);
      case (mode)
         0:       o_ready = 1'b1;
         1:       o_ready = (n % 3 == 0);
         default: o_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   // extra_at >= 0 injects a second start that cycle; it must be ignored
   task automatic run_burst(input int b, input int l, input int mode, input int extra_at);
      int n, d0;
      for (int i = 0; i < l; i++) exp_q.push_back({(i == l-1), mem[(b+i) % DEPTH]});
      addr_got.delete();
      d0 = done_cnt;
      base = WADDR'(b); len = (WADDR+1)'(l); start = 1'b1;
      set_ready(mode, 0);
      cyc();
      start = 1'b0;
      n = 0;
      while (done_cnt == d0 && n < 400) begin
         if (n == extra_at) begin
            base = 5'd10; len = 6'd3; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         set_ready(mode, n+1);
         cyc();
         n++;
      end
      start = 1'b0;
      o_ready = 1'b1;
      check_eq("done_seen", 64'(done_cnt - d0), 64'd1);
      check_eq("beats_left", 64'(exp_q.size()), 64'd0);
      check_eq("addr_count", 64'(addr_got.size()), 64'(l));
      for (int i = 0; i < l && i < addr_got.size(); i++)
         check_eq("addr_seq", 64'(addr_got[i]), 64'((b+i) % DEPTH));
      exp_q.delete();
      addr_got.delete();
   endtask

   initial begin
      int i0, d0, p0, n;
      for (int i = 0; i < DEPTH; i++) mem[i] = WWORD'(i + 100);
      repeat (3) cyc();
      @(negedge clk);
      check_eq("rst_outputs", {busy, done, cena, aa, o_valid, o_last, o_data},
               {1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 32'd0});
      cyc();
      rst = 1'b0;
      repeat (2) cyc();

      // Directed timing: base=3 len=4 with o_ready held
      for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), WWORD'(103 + i)});
      base = 5'd3; len = 6'd4; start = 1'b1; o_ready = 1'b1;
      cyc();
      start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check_eq($sformatf("t1_cena_%0d", k), 64'(cena), 64'(!(k <= 4)));
         if (k <= 4) check_eq($sformatf("t1_aa_%0d", k), 64'(aa), 64'(2 + k));
         check_eq($sformatf("t1_valid_%0d", k), 64'(o_valid), 64'(k >= 3 && k <= 6));
         if (k >= 3 && k <= 6)
            check_eq($sformatf("t1_beat_%0d", k), {o_last, o_data}, {(k == 6), WWORD'(100 + k)});
         check_eq($sformatf("t1_done_%0d", k), 64'(done), 64'(k == 7));
         check_eq($sformatf("t1_busy_%0d", k), 64'(busy), 64'(k <= 6));
      end
      cyc();
      exp_q.delete();
      addr_got.delete();

      run_burst(22, 5, 0, -1);      // wrap past DEPTH-1
      run_burst(0, 8, 1, -1);       // ready pattern 1,0,0
      run_burst(7, DEPTH, 2, -1);   // full wrap with random backpressure

      // len=0: immediate done, no reads
      i0 = issue_cnt;
      base = 5'd4; len = 6'd0; start = 1'b1;
      cyc();
      start = 1'b0;
      @(negedge clk);
      check_eq("len0_done", {done, busy, cena}, {1'b1, 1'b0, 1'b1});
      cyc();
      @(negedge clk);
      check_eq("len0_done_clear", {done, busy}, 2'b00);
      check_eq("len0_no_issue", 64'(issue_cnt - i0), 64'd0);

      // start while busy is ignored
      run_burst(0, 6, 0, 2);
      i0 = issue_cnt;
      repeat (5) cyc();
      check_eq("busy_start_no_issue", 64'(issue_cnt - i0), 64'd0);
      check_eq("busy_start_idle", {o_valid, busy}, 2'b00);

      // Reset mid-burst after two beats
      for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), mem[i]});
      p0 = pop_cnt;
      base = 5'd0; len = 6'd8; start = 1'b1; o_ready = 1'b1;
      cyc();
      start = 1'b0;
      n = 0;
      while (pop_cnt - p0 < 2 && n < 50) begin cyc(); n++; end
      check_eq("rst_mid_two_beats", 64'(pop_cnt - p0), 64'd2);
      rst = 1'b1;
      cyc();
      @(negedge clk);
      check_eq("rst_mid_outputs", {busy, done, cena, aa, o_valid, o_last, o_data},
               {1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 32'd0});
      cyc();
      rst = 1'b0;
      exp_q.delete();
      addr_got.delete();
      d0 = done_cnt;
      repeat (4) cyc();
      check_eq("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
      p0 = pop_cnt;
      run_burst(5, 2, 0, -1);
      check_eq("rst_mid_new_beats", 64'(pop_cnt - p0), 64'd2);

      // Random bursts over random memory contents
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();
      for (int t = 0; t < 12; t++)
         run_burst(int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, DEPTH)), 2, -1);

      repeat (2) cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
